mul_seq: RTL and testbench

Iterative 64-bit integer multiplier for the ALU's M-extension path, complementing the combinational divide/remainder unit. Accepts two 64-bit operands and a 2-bit op select (mul / mulh / mulhsu / mulhu) over a valid/ready handshake. Computes the 128-bit product one multiplier bit per cycle with a shift-add datapath. Holds the selected 64-bit half until the consumer takes it.

---
 rtl/mul_seq.sv | 147 ++++++++++++++
 tb/tb_mul_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Iterative 64x64 shift-add multiplier (mul/mulh/mulhsu/mulhu), one multiplier bit per cycle.
// Optional MUL_EARLY_OUT_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in1,
    input  logic [63:0] in2,
    input  logic [1:0]  control,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] out,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned W  = 64;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = 6;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      ctrl_q, ctrl_d;
    logic            neg1_q, neg1_d;
    logic            neg2_q, neg2_d;
    logic [W-1:0]    out_d;
    logic            out_valid_d;
    logic            in_ready_d;

    logic            sgn1, sgn2;
    logic            early;
    logic [PW-1:0]   prod;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            neg1_q    <= neg1_d;
            neg2_q    <= neg2_d;
            out       <= out_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        ctrl_d      = ctrl_q;
        neg1_d      = neg1_q;
        neg2_d      = neg2_q;
        out_d       = out;
        out_valid_d = out_valid;
        in_ready_d  = 1'b0;

        sgn1  = ((control == OP_MULH) || (control == OP_MULHSU)) ? in1[W-1] : 1'b0;
        sgn2  = (control == OP_MULH) ? in2[W-1] : 1'b0;
        prod  = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
        early = 1'b0;
`ifdef MUL_EARLY_OUT_EN
        early = (mplier_q == '0);
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ctrl_d   = control;
                    neg1_d   = sgn1;
                    neg2_d   = sgn2;
                    // Two's-complement magnitude; 2^63 stays exact as unsigned
                    mcand_d  = {{W{1'b0}}, (sgn1 ? -in1 : in1)};
                    mplier_d = sgn2 ? -in2 : in2;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (early) begin
                    state_d = FIX;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                acc_d       = prod;
                out_d       = (ctrl_q == OP_MUL) ? prod[W-1:0] : prod[PW-1:W];
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: directed vectors, latency, backpressure and mid-op reset.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in1, in2;
    logic [1:0]  control;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out;
    logic        out_valid;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [63:0] data;
        int          lat;
        int          c0;
        string       name;
    } exp_t;

    exp_t sb[$];

    mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in1       (in1),
        .in2       (in2),
        .control   (control),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic int exp_lat(input logic [63:0] b, input logic [1:0] c);
`ifdef MUL_EARLY_OUT_EN
        logic [63:0] m;
        int hi;
        m  = (c == 2'b01 && b[63]) ? -b : b;
        hi = 0;
        if (m == 64'd0) return 2;
        for (int i = 0; i < 64; i++) if (m[i]) hi = i;
        return (hi + 3 > 65) ? 65 : hi + 3;
`else
        return 65 + 0 * int'({b[0], c});
`endif
    endfunction

    // Monitor: compare each new result against the head of the scoreboard
    logic ov_prev = 1'b0;
    always @(negedge clk) begin
        if (out_valid && !ov_prev) begin
            if (sb.size() == 0) begin
                check("unexpected output", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, " data"}, out, e.data);
                check({e.name, " latency"}, 64'(cyc - e.c0), 64'(e.lat));
            end
        end
        ov_prev = out_valid;
    end

    // Accept one op at the next opportunity; returns with the caller just past the acceptance edge
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c,
                         output int c0);
        int t;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("in_ready before issue", 64'(in_ready), 64'd1);
        in1 = a; in2 = b; control = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_valid(input string nm);
        int t;
        int busy_bad;
        t = 0;
        busy_bad = 0;
        while (!out_valid && t < 200) begin
            if (in_ready) busy_bad++;
            @(posedge clk); #1;
            t++;
        end
        check({nm, " out_valid timeout"}, 64'(out_valid), 64'd1);
        check({nm, " in_ready while busy"}, 64'(busy_bad), 64'd0);
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c,
                          input logic [63:0] e, input string nm);
        int c0;
        exp_t x;
        issue(a, b, c, c0);
        x.data = e; x.lat = exp_lat(b, c); x.c0 = c0; x.name = nm;
        sb.push_back(x);
        wait_valid(nm);
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    localparam int NV = 11;
    logic [63:0] va [NV] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'h8000_0000_0000_0000, 64'd5, 64'h1234, 64'd3,
                             64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD};
    logic [63:0] vb [NV] = '{64'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                             64'h8000_0000_0000_0000, 64'd1, 64'd0,
                             64'h8000_0000_0000_0000, 64'd5, 64'd5};
    logic [1:0]  vc [NV] = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11,
                             2'b11, 2'b01, 2'b00};
    logic [63:0] ve [NV] = '{64'h2A, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000,
                             64'd5, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'hFFFF_FFFF_FFFF_FFF1};

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int unstable;
        exp_t x;

        rst = 1'b1; in1 = '0; in2 = '0; control = '0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out", out, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op(va[i], vb[i], vc[i], ve[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result and valid hold, stray in_valid ignored
        out_ready = 1'b0;
        issue(64'h10, 64'h10, 2'b00, c0);
        x.data = 64'h100; x.lat = exp_lat(64'h10, 2'b00); x.c0 = c0; x.name = "bp";
        sb.push_back(x);
        wait_valid("bp");
        unstable = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in1 = 64'd99; in2 = 64'd77; in_valid = k[0];
            @(posedge clk); #1;
            if (out !== 64'h100 || out_valid !== 1'b1 || in_ready !== 1'b0) unstable++;
        end
        check("bp hold", 64'(unstable), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp out_valid falls", 64'(out_valid), 64'd0);
        check("bp in_ready rises", 64'(in_ready), 64'd1);
        check("bp out kept", out, 64'h100);
        @(negedge clk);

        // Reset mid-BUSY drops the op
        issue(64'd9, 64'd9, 2'b00, c0);
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out", out, 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        run_op(64'd3, 64'd5, 2'b00, 64'd15, "after rst");

        repeat (5) @(negedge clk);
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
